// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station slice.
// Holds the machine-wide data/tag widths and the RV32I opcode values of the
// instruction classes that pass through the reservation station.
// No ports; imported by the interface, the selector and the top level.
package reservation_station_pkg;

    localparam int DATA_WID = 32;
    localparam int ROB_WID  = 4;
    localparam int RS_WID   = 4;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BR     = 7'b1100011;
    localparam logic [6:0] OPCODE_ARITHI = 7'b0010011;
    localparam logic [6:0] OPCODE_ARITH  = 7'b0110011;

endpackage

// File: rtl/reservation_station_if.sv
// Bus bundle around the reservation station.
// Groups the issue request, the two result broadcast buses (ALU, LSB), the
// full flag and the registered ALU dispatch bundle.
//   master : issue stage / broadcast sources / ALU consumer side
//   slave  : the reservation station itself
interface reservation_station_if
    import reservation_station_pkg::*;
#(
    parameter int ROB_BITS = ROB_WID
);
    logic                iss_en;
    logic [6:0]          iss_opcode;
    logic [2:0]          iss_funct3;
    logic                iss_funct7;
    logic [31:0]         iss_val1;
    logic [31:0]         iss_val2;
    logic                iss_has_dep1;
    logic                iss_has_dep2;
    logic [ROB_BITS-1:0] iss_dep1;
    logic [ROB_BITS-1:0] iss_dep2;
    logic [31:0]         iss_imm;
    logic [31:0]         iss_pc;
    logic [ROB_BITS-1:0] iss_rob_pos;

    logic                alu_res_done;
    logic [ROB_BITS-1:0] alu_res_rob_pos;
    logic [31:0]         alu_res_cal;
    logic                lsb_res_done;
    logic [ROB_BITS-1:0] lsb_res_rob_pos;
    logic [31:0]         lsb_res_val;

    logic                rs_full;

    logic                alu_en;
    logic [6:0]          alu_opcode;
    logic [2:0]          alu_funct3;
    logic                alu_funct7;
    logic [31:0]         alu_val1;
    logic [31:0]         alu_val2;
    logic [31:0]         alu_imm;
    logic [ROB_BITS-1:0] alu_rob_pos;
    logic [31:0]         alu_pc;

    modport master (
        output iss_en, iss_opcode, iss_funct3, iss_funct7, iss_val1, iss_val2,
               iss_has_dep1, iss_has_dep2, iss_dep1, iss_dep2, iss_imm,
               iss_pc, iss_rob_pos,
               alu_res_done, alu_res_rob_pos, alu_res_cal,
               lsb_res_done, lsb_res_rob_pos, lsb_res_val,
        input  rs_full,
               alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1,
               alu_val2, alu_imm, alu_rob_pos, alu_pc
    );

    modport slave (
        input  iss_en, iss_opcode, iss_funct3, iss_funct7, iss_val1, iss_val2,
               iss_has_dep1, iss_has_dep2, iss_dep1, iss_dep2, iss_imm,
               iss_pc, iss_rob_pos,
               alu_res_done, alu_res_rob_pos, alu_res_cal,
               lsb_res_done, lsb_res_rob_pos, lsb_res_val,
        output rs_full,
               alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1,
               alu_val2, alu_imm, alu_rob_pos, alu_pc
    );

endinterface

// File: rtl/reservation_station_select.sv
// rs_select: lowest-index priority encoder.
// Ports:
//   mask  in  N  request bits
//   idx   out W  index of the lowest set bit (0 when none)
//   found out 1  at least one bit of mask is set
module rs_select #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scanning downward lets the lowest set bit be the last assignment.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: holds ALU-class instructions until both operands are
// resolved, snoops the ALU/LSB broadcast buses for wakeup, and dispatches the
// lowest-index ready entry per cycle into a registered ALU input bundle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rdy           global enable; low freezes all state
//   rollback      misprediction flush (acts like reset for entries/outputs)
//   bus           reservation_station_if.slave (issue, broadcasts, rs_full,
//                 alu_* dispatch bundle)
//   perf_dispatch_cnt, perf_full_cnt  only when RS_PERF_EN is defined
// Optional feature macro: RS_PERF_EN (dispatch / full-cycle counters).
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE  = 16,
    parameter int RS_BITS  = 4,
    parameter int ROB_BITS = ROB_WID
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    reservation_station_if.slave bus
`ifdef RS_PERF_EN
    ,
    output logic [31:0]          perf_dispatch_cnt,
    output logic [31:0]          perf_full_cnt
`endif
);

    typedef struct packed {
        logic                has_dep;
        logic [ROB_BITS-1:0] dep;
        logic [31:0]         val;
    } operand_t;

    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic                funct7;
        operand_t            op1;
        operand_t            op2;
        logic [31:0]         imm;
        logic [31:0]         pc;
        logic [ROB_BITS-1:0] rob_pos;
    } entry_t;

    // Capture a broadcast for a pending operand; ALU bus has priority.
    function automatic operand_t wake(
        input operand_t            op,
        input logic                a_done,
        input logic [ROB_BITS-1:0] a_tag,
        input logic [31:0]         a_val,
        input logic                l_done,
        input logic [ROB_BITS-1:0] l_tag,
        input logic [31:0]         l_val
    );
        operand_t r;
        r = op;
        if (op.has_dep) begin
            if (a_done && a_tag == op.dep) begin
                r.has_dep = 1'b0;
                r.val     = a_val;
            end else if (l_done && l_tag == op.dep) begin
                r.has_dep = 1'b0;
                r.val     = l_val;
            end
        end
        return r;
    endfunction

    entry_t               ent      [RS_SIZE];
    entry_t               ent_next [RS_SIZE];
    entry_t               iss_entry;
    logic [RS_SIZE-1:0]   busy;
    logic [RS_SIZE-1:0]   free_mask;
    logic [RS_SIZE-1:0]   ready_mask;
    logic [RS_BITS-1:0]   free_idx;
    logic [RS_BITS-1:0]   ready_idx;
    logic                 free_found;
    logic                 ready_found;
    logic                 iss_accept;
    logic                 flush;

    assign flush       = rst || rollback;
    assign free_mask   = ~busy;
    // Only registered busy bits count: a slot dispatched this cycle is not
    // reusable until the next one.
    assign bus.rs_full = &busy;
    assign iss_accept  = bus.iss_en && free_found;

    rs_select #(.N(RS_SIZE), .W(RS_BITS)) u_free_sel (
        .mask  (free_mask),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_select #(.N(RS_SIZE), .W(RS_BITS)) u_ready_sel (
        .mask  (ready_mask),
        .idx   (ready_idx),
        .found (ready_found)
    );

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_mask[i] = busy[i] & ~ent[i].op1.has_dep & ~ent[i].op2.has_dep;
            ent_next[i]     = ent[i];
            ent_next[i].op1 = wake(ent[i].op1, bus.alu_res_done, bus.alu_res_rob_pos,
                                   bus.alu_res_cal, bus.lsb_res_done,
                                   bus.lsb_res_rob_pos, bus.lsb_res_val);
            ent_next[i].op2 = wake(ent[i].op2, bus.alu_res_done, bus.alu_res_rob_pos,
                                   bus.alu_res_cal, bus.lsb_res_done,
                                   bus.lsb_res_rob_pos, bus.lsb_res_val);
        end
    end

    // Same-cycle bypass: the issuing instruction sees this cycle's broadcasts.
    always_comb begin
        iss_entry.opcode  = bus.iss_opcode;
        iss_entry.funct3  = bus.iss_funct3;
        iss_entry.funct7  = bus.iss_funct7;
        iss_entry.imm     = bus.iss_imm;
        iss_entry.pc      = bus.iss_pc;
        iss_entry.rob_pos = bus.iss_rob_pos;
        iss_entry.op1 = wake('{bus.iss_has_dep1, bus.iss_dep1, bus.iss_val1},
                             bus.alu_res_done, bus.alu_res_rob_pos, bus.alu_res_cal,
                             bus.lsb_res_done, bus.lsb_res_rob_pos, bus.lsb_res_val);
        iss_entry.op2 = wake('{bus.iss_has_dep2, bus.iss_dep2, bus.iss_val2},
                             bus.alu_res_done, bus.alu_res_rob_pos, bus.alu_res_cal,
                             bus.lsb_res_done, bus.lsb_res_rob_pos, bus.lsb_res_val);
    end

    // Entry payload: not reset; validity is carried by busy alone.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= ent_next[i];
            end
            if (iss_accept) begin
                ent[free_idx] <= iss_entry;
            end
        end
    end

    // Control and registered dispatch bundle.
    always_ff @(posedge clk) begin
        if (flush) begin
            busy            <= '0;
            bus.alu_en      <= 1'b0;
            bus.alu_opcode  <= '0;
            bus.alu_funct3  <= '0;
            bus.alu_funct7  <= 1'b0;
            bus.alu_val1    <= '0;
            bus.alu_val2    <= '0;
            bus.alu_imm     <= '0;
            bus.alu_rob_pos <= '0;
            bus.alu_pc      <= '0;
        end else if (rdy) begin
            bus.alu_en <= ready_found;
            if (ready_found) begin
                busy[ready_idx] <= 1'b0;
                bus.alu_opcode  <= ent[ready_idx].opcode;
                bus.alu_funct3  <= ent[ready_idx].funct3;
                bus.alu_funct7  <= ent[ready_idx].funct7;
                bus.alu_val1    <= ent[ready_idx].op1.val;
                bus.alu_val2    <= ent[ready_idx].op2.val;
                bus.alu_imm     <= ent[ready_idx].imm;
                bus.alu_rob_pos <= ent[ready_idx].rob_pos;
                bus.alu_pc      <= ent[ready_idx].pc;
            end
            // Issue slot is free, so it can never collide with the dispatch slot.
            if (iss_accept) begin
                busy[free_idx] <= 1'b1;
            end
        end
    end

`ifdef RS_PERF_EN
    // Counters survive rollback; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dispatch_cnt <= '0;
            perf_full_cnt     <= '0;
        end else if (rdy) begin
            if (!rollback && ready_found) begin
                perf_dispatch_cnt <= perf_dispatch_cnt + 32'd1;
            end
            if (bus.rs_full) begin
                perf_full_cnt <= perf_full_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
